// File: rtl/ap_ctrl_perf_monitor_pkg.sv
// Shared types and saturating arithmetic for the ap_ctrl handshake performance monitor.
// Statistic fields are carried at STAT_W bits and narrowed by the consumer.
package perf_mon_pkg;

  localparam int unsigned STAT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [STAT_W-1:0] start_cnt;
    logic [STAT_W-1:0] done_cnt;
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] lat_min;
    logic [STAT_W-1:0] lat_max;
    logic [STAT_W-1:0] lat_sum;
  } perf_stats_t;

  // All-ones value of a w-bit field, held in STAT_W bits.
  function automatic logic [STAT_W-1:0] sat_max(input int unsigned w);
    logic [STAT_W-1:0] m;
    if (w >= STAT_W) begin
      m = '1;
    end else begin
      m = (64'd1 << w) - 64'd1;
    end
    return m;
  endfunction

  // Increment a w-bit value, sticking at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input int unsigned w);
    logic [STAT_W-1:0] m;
    logic [STAT_W-1:0] r;
    m = sat_max(w);
    if (v >= m) begin
      r = m;
    end else begin
      r = v + 64'd1;
    end
    return r;
  endfunction

  // Add two w-bit values, clamping the result at all-ones.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [STAT_W-1:0] b,
                                                input int unsigned w);
    logic [STAT_W-1:0] m;
    logic [STAT_W:0]   s;
    logic [STAT_W-1:0] r;
    m = sat_max(w);
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, m}) begin
      r = m;
    end else begin
      r = s[STAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ap_ctrl_perf_monitor_if.sv
// Bundle of NUM_CH ap_ctrl_hs / ap_ctrl_chain handshake lines.
// master drives the handshake (kernel side or bench), slave observes it (the monitor).
interface ap_ctrl_perf_monitor_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;

  modport master (output ap_start, output ap_ready, output ap_done, output ap_continue);
  modport slave  (input  ap_start, input  ap_ready, input  ap_done, input  ap_continue);
endinterface

// File: rtl/ap_ctrl_perf_monitor_chan_stats.sv
// Single-channel handshake tracker: IDLE/RUN/HOLD FSM, latency measurement and
// saturating statistics. Statistics hold while freeze_i is high; the FSM keeps tracking.
// Optional watchdog under PERF_MON_WATCHDOG_EN.
module ap_ctrl_chan_stats
  import perf_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LAT_W = 16
`ifdef PERF_MON_WATCHDOG_EN
  , parameter int unsigned WDOG_LIMIT = 65535
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        freeze_i,
  input  logic        ap_start_i,
  input  logic        ap_ready_i,
  input  logic        ap_done_i,
  input  logic        ap_continue_i,
  output logic        busy_o,
`ifdef PERF_MON_WATCHDOG_EN
  output logic        wdog_flag_o,
`endif
  output perf_stats_t stats_o
);

  ch_state_e        state_q, state_d;
  // lat_cur_q holds the cycles elapsed since t0 (1 in the cycle after t0).
  logic [LAT_W-1:0] lat_cur_q, lat_cur_d;
  logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [LAT_W-1:0] lat_min_q, lat_min_d;
  logic [LAT_W-1:0] lat_max_q, lat_max_d;
  logic [CNT_W-1:0] lat_sum_q, lat_sum_d;
  logic             rec_s;
  logic             retire_s;
  logic [LAT_W-1:0] rec_lat_s;

  // Next-state logic: decides when a latency is recorded and a transaction retires.
  always_comb begin
    state_d   = state_q;
    lat_cur_d = lat_cur_q;
    rec_s     = 1'b0;
    retire_s  = 1'b0;
    rec_lat_s = lat_cur_q;
    case (state_q)
      IDLE: begin
        if (ap_start_i) begin
          lat_cur_d = LAT_W'(1);
          if (ap_done_i) begin
            rec_s     = 1'b1;
            rec_lat_s = '0;
            if (ap_continue_i) begin
              retire_s = 1'b1;
              state_d  = RUN;
            end else begin
              state_d = HOLD;
            end
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (ap_done_i) begin
          rec_s = 1'b1;
          if (ap_continue_i) begin
            retire_s = 1'b1;
            if (ap_start_i) begin
              state_d   = RUN;
              lat_cur_d = LAT_W'(1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = HOLD;
          end
        end else begin
          lat_cur_d = LAT_W'(sat_inc(STAT_W'(lat_cur_q), LAT_W));
        end
      end
      HOLD: begin
        if (ap_continue_i) begin
          retire_s = 1'b1;
          if (ap_start_i) begin
            state_d   = RUN;
            lat_cur_d = LAT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Statistic updates, all suppressed while frozen.
  always_comb begin
    start_cnt_d = start_cnt_q;
    done_cnt_d  = done_cnt_q;
    stall_cnt_d = stall_cnt_q;
    lat_min_d   = lat_min_q;
    lat_max_d   = lat_max_q;
    lat_sum_d   = lat_sum_q;
    if (!freeze_i && ap_start_i && ap_ready_i) begin
      start_cnt_d = CNT_W'(sat_inc(STAT_W'(start_cnt_q), CNT_W));
    end else begin
      start_cnt_d = start_cnt_q;
    end
    if (!freeze_i && retire_s) begin
      done_cnt_d = CNT_W'(sat_inc(STAT_W'(done_cnt_q), CNT_W));
    end else begin
      done_cnt_d = done_cnt_q;
    end
    if (!freeze_i && (state_q == HOLD)) begin
      stall_cnt_d = CNT_W'(sat_inc(STAT_W'(stall_cnt_q), CNT_W));
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!freeze_i && rec_s) begin
      lat_min_d = (rec_lat_s < lat_min_q) ? rec_lat_s : lat_min_q;
      lat_max_d = (rec_lat_s > lat_max_q) ? rec_lat_s : lat_max_q;
      lat_sum_d = CNT_W'(sat_add(STAT_W'(lat_sum_q), STAT_W'(rec_lat_s), CNT_W));
    end else begin
      lat_min_d = lat_min_q;
      lat_max_d = lat_max_q;
      lat_sum_d = lat_sum_q;
    end
  end

  // State, measurement and statistic registers; reset discards any in-flight measurement.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cur_q   <= '0;
      start_cnt_q <= '0;
      done_cnt_q  <= '0;
      stall_cnt_q <= '0;
      lat_min_q   <= {LAT_W{1'b1}};
      lat_max_q   <= '0;
      lat_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_cur_q   <= lat_cur_d;
      start_cnt_q <= start_cnt_d;
      done_cnt_q  <= done_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      lat_min_q   <= lat_min_d;
      lat_max_q   <= lat_max_d;
      lat_sum_q   <= lat_sum_d;
    end
  end

  assign busy_o            = (state_q != IDLE);
  assign stats_o.start_cnt = STAT_W'(start_cnt_q);
  assign stats_o.done_cnt  = STAT_W'(done_cnt_q);
  assign stats_o.stall_cnt = STAT_W'(stall_cnt_q);
  assign stats_o.lat_min   = STAT_W'(lat_min_q);
  assign stats_o.lat_max   = STAT_W'(lat_max_q);
  assign stats_o.lat_sum   = STAT_W'(lat_sum_q);

`ifdef PERF_MON_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        wd_flag_q;

  // Count consecutive busy cycles; flag once the count passes WDOG_LIMIT, even while frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q  <= 32'd0;
      wd_flag_q <= 1'b0;
    end else begin
      wd_cnt_q  <= busy_o ? 32'(sat_inc(STAT_W'(wd_cnt_q), 32)) : 32'd0;
      wd_flag_q <= wd_flag_q | (busy_o && (wd_cnt_q >= 32'(WDOG_LIMIT)));
    end
  end

  assign wdog_flag_o = wd_flag_q;
`endif

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl handshake performance monitor: one ap_ctrl_chan_stats per channel,
// sticky freeze on finish and a registered channel-select readout.
// Optional watchdog (WDOG_LIMIT parameter, wdog_flag port) under PERF_MON_WATCHDOG_EN.
module ap_ctrl_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LAT_W  = 16,
`ifdef PERF_MON_WATCHDOG_EN
  parameter int unsigned WDOG_LIMIT = 65535,
`endif
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  ap_ctrl_perf_monitor_if.slave  hs,
  input  logic                   finish,
  input  logic [SEL_W-1:0]       rd_sel,
  output logic [CNT_W-1:0]       rd_start_cnt,
  output logic [CNT_W-1:0]       rd_done_cnt,
  output logic [CNT_W-1:0]       rd_stall_cnt,
  output logic [LAT_W-1:0]       rd_lat_min,
  output logic [LAT_W-1:0]       rd_lat_max,
  output logic [CNT_W-1:0]       rd_lat_sum,
  output logic                   rd_busy,
`ifdef PERF_MON_WATCHDOG_EN
  output logic [NUM_CH-1:0]      wdog_flag,
`endif
  output logic                   frozen
);

  perf_stats_t       stats_s [NUM_CH];
  logic [NUM_CH-1:0] busy_s;
  perf_stats_t       rd_stats_s;
  logic              rd_busy_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ctrl_chan_stats #(
      .CNT_W(CNT_W),
      .LAT_W(LAT_W)
`ifdef PERF_MON_WATCHDOG_EN
      , .WDOG_LIMIT(WDOG_LIMIT)
`endif
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .freeze_i      (frozen),
      .ap_start_i    (hs.ap_start[g]),
      .ap_ready_i    (hs.ap_ready[g]),
      .ap_done_i     (hs.ap_done[g]),
      .ap_continue_i (hs.ap_continue[g]),
      .busy_o        (busy_s[g]),
`ifdef PERF_MON_WATCHDOG_EN
      .wdog_flag_o   (wdog_flag[g]),
`endif
      .stats_o       (stats_s[g])
    );
  end

  // Freeze becomes active the edge after finish, so a retirement in the finish cycle still counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      frozen <= 1'b0;
    end else begin
      frozen <= frozen | finish;
    end
  end

  // Select the addressed channel; an out-of-range select reads as zeros.
  always_comb begin
    rd_stats_s = '0;
    rd_busy_d  = 1'b0;
    if (32'(rd_sel) < NUM_CH) begin
      rd_stats_s = stats_s[rd_sel];
      rd_busy_d  = busy_s[rd_sel];
    end else begin
      rd_stats_s = '0;
      rd_busy_d  = 1'b0;
    end
  end

  // Readout register: captures the pre-update statistics of the selected channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_start_cnt <= '0;
      rd_done_cnt  <= '0;
      rd_stall_cnt <= '0;
      rd_lat_min   <= '0;
      rd_lat_max   <= '0;
      rd_lat_sum   <= '0;
      rd_busy      <= 1'b0;
    end else begin
      rd_start_cnt <= CNT_W'(rd_stats_s.start_cnt);
      rd_done_cnt  <= CNT_W'(rd_stats_s.done_cnt);
      rd_stall_cnt <= CNT_W'(rd_stats_s.stall_cnt);
      rd_lat_min   <= LAT_W'(rd_stats_s.lat_min);
      rd_lat_max   <= LAT_W'(rd_stats_s.lat_max);
      rd_lat_sum   <= CNT_W'(rd_stats_s.lat_sum);
      rd_busy      <= rd_busy_d;
    end
  end

endmodule
